alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 143 ++++++++++++++
 tb/tb_alu_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pipe : two-stage valid/ready ALU with sticky, maskable IRQ flags      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module alu_pipe #(
  parameter int DATA_W = 8,
  parameter int IRQ_W  = 3
) (
  input  logic              alu_clk,
  input  logic              rst,
  input  logic              alu_in_valid,
  output logic              alu_in_ready,
  input  logic [DATA_W-1:0] alu_in_a,
  input  logic [DATA_W-1:0] alu_in_b,
  input  logic [1:0]        alu_mode,
  input  logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_out_valid,
  input  logic              alu_out_ready,
  input  logic [IRQ_W-1:0]  alu_irq_en,
  input  logic [IRQ_W-1:0]  alu_irq_clr,
  output logic [IRQ_W-1:0]  alu_irq_status,
  output logic              alu_irq
);

  logic              r_live;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [1:0]        r_s1_mode;
  logic [1:0]        r_s1_op;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_res;
  logic [IRQ_W-1:0]  r_status;

  logic              w_s2_load;
  logic              w_in_fire;
  logic [DATA_W:0]   w_add;
  logic [DATA_W:0]   w_sub;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;
  logic              w_merr;
  logic              w_zero;
  logic [IRQ_W-1:0]  w_set;

  assign w_s2_load    = r_s1_valid && (!r_s2_valid || alu_out_ready);
  // r_live keeps ready low during reset and raises it one edge after release
  assign alu_in_ready = r_live && (!r_s1_valid || w_s2_load);
  assign w_in_fire    = alu_in_valid && alu_in_ready;

  assign w_add = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_sub = {1'b0, r_s1_a} - {1'b0, r_s1_b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_merr  = 1'b0;
    case (r_s1_mode)
      2'b00: begin
        case (r_s1_op)
          2'b00:   w_res = r_s1_a & r_s1_b;
          2'b01:   w_res = ~(r_s1_a & r_s1_b);
          2'b10:   w_res = r_s1_a | r_s1_b;
          default: w_res = r_s1_a ^ r_s1_b;
        endcase
      end
      2'b01: begin
        case (r_s1_op)
          2'b00:   w_res = ~(r_s1_a ^ r_s1_b);
          2'b01:   w_res = r_s1_a & r_s1_b;
          2'b10:   w_res = ~(r_s1_a | r_s1_b);
          default: w_res = r_s1_a | r_s1_b;
        endcase
      end
      2'b10: begin
        case (r_s1_op)
          2'b00: begin
            w_res   = w_add[DATA_W-1:0];
            w_carry = w_add[DATA_W];
          end
          2'b01: begin
            // top bit of the widened difference is the borrow (a < b)
            w_res   = w_sub[DATA_W-1:0];
            w_carry = w_sub[DATA_W];
          end
          2'b10: begin
            w_res   = {r_s1_a[DATA_W-2:0], 1'b0};
            w_carry = r_s1_a[DATA_W-1];
          end
          default: begin
            w_res   = {1'b0, r_s1_a[DATA_W-1:1]};
            w_carry = r_s1_a[0];
          end
        endcase
      end
      default: w_merr = 1'b1;
    endcase
  end

  assign w_zero = (w_res == '0);
  assign w_set  = {IRQ_W{w_s2_load}} & alu_irq_en & {w_merr, w_carry, w_zero};

  always_ff @(posedge alu_clk or posedge rst) begin
    if (rst) begin
      r_live     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
      r_s1_op    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_status   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= alu_in_a;
        r_s1_b     <= alu_in_b;
        r_s1_mode  <= alu_mode;
        r_s1_op    <= alu_op;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_res   <= w_res;
      end else if (alu_out_ready) begin
        r_s2_valid <= 1'b0;
      end
      // a new set wins over a simultaneous clear
      r_status <= (r_status & ~alu_irq_clr) | w_set;
    end
  end

  assign alu_out        = r_s2_res;
  assign alu_out_valid  = r_s2_valid;
  assign alu_irq_status = r_status;
  assign alu_irq        = |r_status;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// tb_alu_pipe : scoreboard bench for alu_pipe (DATA_W = 8)
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [1:0] mode = '0;
  logic [1:0] op = '0;
  logic [7:0] out_d;
  logic       out_valid;
  logic       out_ready;
  logic       rdy_force = 1'b1;
  logic       rand_rdy = 1'b0;
  logic       rr = 1'b1;
  logic [2:0] irq_en = '0;
  logic [2:0] irq_clr = '0;
  logic [2:0] status;
  logic       irq;

  int         n_checks = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_out = '0;

  assign out_ready = rand_rdy ? rr : rdy_force;

  alu_pipe #(.DATA_W(8), .IRQ_W(3)) dut (
    .alu_clk       (clk),
    .rst           (rst),
    .alu_in_valid  (in_valid),
    .alu_in_ready  (in_ready),
    .alu_in_a      (in_a),
    .alu_in_b      (in_b),
    .alu_mode      (mode),
    .alu_op        (op),
    .alu_out       (out_d),
    .alu_out_valid (out_valid),
    .alu_out_ready (out_ready),
    .alu_irq_en    (irq_en),
    .alu_irq_clr   (irq_clr),
    .alu_irq_status(status),
    .alu_irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rr = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] m, input logic [1:0] o,
                                       input logic [7:0] a, input logic [7:0] b);
    int r;
    r = 0;
    if (m == 2'd0) begin
      if (o == 2'd0) r = a & b;
      else if (o == 2'd1) r = ~(a & b);
      else if (o == 2'd2) r = a | b;
      else r = a ^ b;
    end else if (m == 2'd1) begin
      if (o == 2'd0) r = ~(a ^ b);
      else if (o == 2'd1) r = a & b;
      else if (o == 2'd2) r = ~(a | b);
      else r = a | b;
    end else if (m == 2'd2) begin
      if (o == 2'd0) r = int'(a) + int'(b);
      else if (o == 2'd1) r = int'(a) - int'(b) + 256;
      else if (o == 2'd2) r = int'(a) * 2;
      else r = int'(a) / 2;
    end
    return r[7:0];
  endfunction

  // output monitor: pop and compare on each transfer, and check hold while stalled
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_stable", out_d, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = out_d;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
        else chk("result", out_d, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [1:0] o,
                      input logic [7:0] a, input logic [7:0] b, input bit push);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; mode = m; op = o; in_a = a; in_b = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (push) exp_q.push_back(model(m, o, a, b));
        acc_cnt++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic clear_all();
    irq_clr = 3'b111;
    @(posedge clk);
    #1 irq_clr = 3'b000;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out_d, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_status", status, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_rst", in_ready, 1);

    // ADD overflow sets zero and carry
    irq_en = 3'b111;
    send(2'b10, 2'b00, 8'hFF, 8'h01, 1'b1);
    drain();
    chk("add_status", status, 3'b011);
    chk("add_irq", irq, 1);
    clear_all();
    chk("clr_status", status, 0);

    send(2'b00, 2'b01, 8'hF0, 8'h3C, 1'b1);
    send(2'b01, 2'b10, 8'hF0, 8'h3C, 1'b1);
    drain();
    chk("logic_status", status, 0);

    // reserved mode and set-beats-clear
    irq_en = 3'b100;
    send(2'b11, 2'b10, 8'h5A, 8'hA5, 1'b1);
    drain();
    chk("merr_status", status, 3'b100);
    send(2'b11, 2'b01, 8'h12, 8'h34, 1'b1);
    irq_clr = 3'b100;
    @(posedge clk);
    #1 irq_clr = 3'b000;
    chk("set_wins_clr", status, 3'b100);
    drain();
    irq_en = 3'b000;
    @(posedge clk);
    #1 chk("en_change_keeps", status, 3'b100);
    irq_clr = 3'b100;
    @(posedge clk);
    #1 irq_clr = 3'b000;
    chk("clr_merr", status, 0);
    chk("clr_irq", irq, 0);

    // random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++)
      send(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    drain();

    // stall with four back-to-back bundles
    rdy_force = 1'b0;
    acc_cnt = 0;
    fork
      begin
        send(2'b00, 2'b11, 8'h11, 8'h22, 1'b1);
        send(2'b01, 2'b00, 8'h33, 8'h0F, 1'b1);
        send(2'b10, 2'b10, 8'h81, 8'h00, 1'b1);
        send(2'b10, 2'b11, 8'h81, 8'h00, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("stall_accepted", acc_cnt, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        rdy_force = 1'b1;
      end
    join
    drain();
    chk("stall_all_accepted", acc_cnt, 4);

    // SUB borrow, then reset with two bundles in flight
    irq_en = 3'b010;
    send(2'b10, 2'b01, 8'h05, 8'h07, 1'b1);
    drain();
    chk("sub_status", status, 3'b010);
    rdy_force = 1'b0;
    send(2'b10, 2'b01, 8'h05, 8'h07, 1'b0);
    send(2'b00, 2'b00, 8'hFF, 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_status", status, 0);
    chk("midrst_out", out_d, 0);
    @(negedge clk) rst = 1'b0;
    rdy_force = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_status", status, 0);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
